ex_div_unit: RTL and testbench
==============================

# ex_div_unit

Iterative 32-bit integer divider that serves as the responder on the `ex_div` connection. The execute stage drives the operands, `op` and a `start` pulse; this block runs a fixed-latency radix-2 restoring division and returns quotient and remainder with a one-cycle `done` pulse. It implements DIV.W/MOD.W/DIV.WU/MOD.WU: both results are always produced, and `op` selects signedness only.

## Interface
- Parameters: none. Data width is fixed at 32 (`bus32_t`).
- `clk` input 1: clock. One clock domain only.
- `rst` input 1: synchronous, active-high reset.
- `dividend` input 32: dividend operand, sampled only on an accepted start.
- `divisor` input 32: divisor operand, sampled only on an accepted start.
- `op` input 2: 00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU. Signed when `op[1]==0`.
- `start` input 1: request. Accepted only while the block is idle.
- `is_running` output 1: high while a division is in flight, including the `done` cycle.
- `quotient_out` output 32: quotient, valid with `done`, held afterwards.
- `remainder_out` output 32: remainder, valid with `done`, held afterwards.
- `done` output 1: single-cycle result-valid pulse.

## Operation
- States: IDLE, CALC, FINISH.
- **IDLE.** On `start==1`, latch the following, then go to CALC with counter=0:
  - the signed flag;
  - the sign of the dividend, and whether the quotient is negative (signed mode and operand signs differ);
  - the absolute values of both operands (raw values in unsigned mode);
  - a divisor-is-zero flag.
- **Absolute value.** abs(0x80000000) is 0x80000000, interpreted as unsigned.
- **CALC.** Each cycle performs one restoring step on the 33-bit partial remainder R and the 32-bit shift register Q:
  - {R,Q} shifts left 1;
  - trial = R − {1'b0,|divisor|};
  - if trial ≥ 0, R=trial and Q[0]=1; otherwise Q[0]=0.
  - The counter increments each step; after step 32 (counter==31) go to FINISH.
- **FINISH.** Apply signs, drive outputs, `done=1`, then go to IDLE next cycle.
  - quotient_out = negative-quotient flag ? −Q : Q.
  - remainder_out = (signed and dividend negative) ? −R[31:0] : R[31:0].
- **Divide by zero** (either mode): quotient_out=0xFFFFFFFF, remainder_out=dividend exactly as sampled. Latency is unchanged.
- **Signed overflow** 0x80000000 / 0xFFFFFFFF: quotient_out=0x80000000, remainder_out=0. This falls out of the datapath; no special case is needed.
- **`start` outside IDLE** (CALC or FINISH): ignored. Operands are not re-sampled and no second result is produced.
- **Outputs after FINISH:** quotient_out and remainder_out hold their values until the next FINISH.
- **Arithmetic:** two's complement mod 2^32; the remainder magnitude is always < |divisor|.

## Timing
- **Reset** (synchronous, takes priority over all other inputs):
  - state=IDLE, counter=0;
  - is_running=0, done=0, quotient_out=0, remainder_out=0.
- **Reset mid-operation:** the division is abandoned; no `done` appears afterwards.
- **Latency:** if `start` is sampled at edge E0:
  - is_running=1 from E0 through E33;
  - CALC occupies 32 cycles;
  - FINISH (done=1) is the cycle after edge E32, and is_running falls at E33;
  - fixed latency of 33 cycles from the accepting edge to the `done` cycle, independent of operand values.
- **Registered outputs:** all outputs come from flops; there is no combinational path from inputs to outputs.
- **Back-to-back:** the earliest next acceptance is the cycle after FINISH (IDLE). A `start` held high through FINISH is accepted only once IDLE is re-entered.
- **Handshake:**
  - The master must keep `start` a one-cycle pulse or drop it once is_running is seen.
  - Operand values after acceptance are don't-care.

## Test plan
- **Unsigned basic:** DIV.WU 100/7.
  - Response: done exactly 33 cycles after acceptance; quotient=14 (0x0000000E), remainder=2.
  - is_running high for 33 cycles.
- **Signed signs:** 0xFFFFFFF9 (−7) / 2 signed → quotient=0xFFFFFFFD (−3), remainder=0xFFFFFFFF (−1).
  - 7 / 0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1.
- **Overflow and unsigned reinterpretation:** 0x80000000 / 0xFFFFFFFF.
  - Signed → quotient=0x80000000, remainder=0.
  - Unsigned → quotient=0, remainder=0x80000000.
- **Divide by zero:** 0x12345678 / 0, both modes → quotient=0xFFFFFFFF, remainder=0x12345678, done at cycle 33.
- **Start while busy:** 100/7 accepted, then start with 9/3 at cycle 10.
  - Response: a single done at cycle 33 with 14/2.
  - 9/3 accepted after return to IDLE gives quotient=3, remainder=0, 33 cycles later.
- **Reset mid-operation:** rst at cycle 15 of a division.
  - Next cycle: is_running=0, outputs=0, no done.
  - A new start afterwards completes normally.

Source files
------------

// File: rtl/ex_div_unit.sv
// Iterative 32-bit radix-2 restoring divider (DIV.W/MOD.W/DIV.WU/MOD.WU).
// Fixed 33-cycle latency from the accepting edge to the single-cycle done pulse.
module ex_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [1:0]  op,
    input  logic        start,
    output logic        is_running,
    output logic [31:0] quotient_out,
    output logic [31:0] remainder_out,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic [32:0] rem_reg, rem_next;
    logic [31:0] quo_reg, quo_next;
    logic [31:0] dvs_reg, dvs_next;
    logic        dvd_neg_reg, dvd_neg_next;
    logic        quo_neg_reg, quo_neg_next;
    logic        div_zero_reg, div_zero_next;
    logic [31:0] quotient_reg, quotient_next;
    logic [31:0] remainder_reg, remainder_next;
    logic        done_reg, done_next;
    logic        running_reg, running_next;

    logic        is_signed;
    logic [33:0] shifted;
    logic [33:0] trial;
    logic [32:0] step_r;
    logic [31:0] step_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            dvd_neg_reg   <= 1'b0;
            quo_neg_reg   <= 1'b0;
            div_zero_reg  <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            done_reg      <= 1'b0;
            running_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rem_reg       <= rem_next;
            quo_reg       <= quo_next;
            dvs_reg       <= dvs_next;
            dvd_neg_reg   <= dvd_neg_next;
            quo_neg_reg   <= quo_neg_next;
            div_zero_reg  <= div_zero_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            done_reg      <= done_next;
            running_reg   <= running_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        dvs_next       = dvs_reg;
        dvd_neg_next   = dvd_neg_reg;
        quo_neg_next   = quo_neg_reg;
        div_zero_next  = div_zero_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        done_next      = 1'b0;
        running_next   = running_reg;
        is_signed      = ~op[1];

        // One restoring step; a set borrow bit means the trial went negative.
        shifted = {rem_reg, quo_reg[31]};
        trial   = shifted - {2'b00, dvs_reg};
        step_r  = trial[33] ? shifted[32:0] : trial[32:0];
        step_q  = {quo_reg[30:0], ~trial[33]};

        case (state_reg)
            IDLE: begin
                if (start) begin
                    dvd_neg_next  = is_signed & dividend[31];
                    quo_neg_next  = is_signed & (dividend[31] ^ divisor[31]);
                    quo_next      = (is_signed & dividend[31]) ? (~dividend + 32'd1) : dividend;
                    dvs_next      = (is_signed & divisor[31]) ? (~divisor + 32'd1) : divisor;
                    div_zero_next = (divisor == 32'd0);
                    rem_next      = '0;
                    count_next    = '0;
                    running_next  = 1'b1;
                    state_next    = CALC;
                end
            end
            CALC: begin
                rem_next   = step_r;
                quo_next   = step_q;
                count_next = count_reg + 5'd1;
                if (count_reg == 5'd31) begin
                    // Results are registered on the last step so done lands in FINISH.
                    // A zero divisor leaves |dividend| in R, so the remainder
                    // restores the original dividend without a special case.
                    if (div_zero_reg)
                        quotient_next = 32'hFFFF_FFFF;
                    else
                        quotient_next = quo_neg_reg ? (~step_q + 32'd1) : step_q;
                    remainder_next = dvd_neg_reg ? (~step_r[31:0] + 32'd1) : step_r[31:0];
                    done_next      = 1'b1;
                    state_next     = FINISH;
                end
            end
            FINISH: begin
                running_next = 1'b0;
                state_next   = IDLE;
            end
            default: begin
                running_next = 1'b0;
                state_next   = IDLE;
            end
        endcase
    end

    assign is_running    = running_reg;
    assign quotient_out  = quotient_reg;
    assign remainder_out = remainder_reg;
    assign done          = done_reg;

endmodule

// File: tb/tb_ex_div_unit.sv
// Self-checking bench for ex_div_unit: directed corner cases plus random operands
// compared against a 64-bit arithmetic reference model.
module tb_ex_div_unit;

    logic        clk;
    logic        rst;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [1:0]  op;
    logic        start;
    logic        is_running;
    logic [31:0] quotient_out;
    logic [31:0] remainder_out;
    logic        done;

    int n_compared;
    int n_mismatched;

    ex_div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .dividend     (dividend),
        .divisor      (divisor),
        .op           (op),
        .start        (start),
        .is_running   (is_running),
        .quotient_out (quotient_out),
        .remainder_out(remainder_out),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp)
        else begin
            n_mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division on widened integers; zero divisor handled by rule.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (!o[1]) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'({32'h0, a});
                sb = longint'({32'h0, b});
            end
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits up to a bound for done; returns edges counted since the accepting edge.
    task automatic wait_done(output int lat, output bit run_ok);
        lat    = 0;
        run_ok = 1'b1;
        while (!done && lat < 40) begin
            if (!is_running) run_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] o);
        logic [31:0] eq, er, held_q;
        int lat;
        bit run_ok;
        model(a, b, o, eq, er);
        dividend = a;
        divisor  = b;
        op       = o;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        wait_done(lat, run_ok);
        $display("%s a=%h b=%h op=%0d q=%h r=%h lat=%0d", tag, a, b, o, quotient_out, remainder_out, lat);
        check({tag, ".latency"}, 32'(lat), 32'd32);
        check({tag, ".running"}, {31'b0, run_ok & is_running}, 32'd1);
        check({tag, ".quotient"}, quotient_out, eq);
        check({tag, ".remainder"}, remainder_out, er);
        held_q = quotient_out;
        tick();
        check({tag, ".done_drop"}, {31'b0, done}, 32'd0);
        check({tag, ".run_drop"}, {31'b0, is_running}, 32'd0);
        check({tag, ".q_held"}, quotient_out, held_q);
    endtask

    initial begin
        int lat, extra;
        bit run_ok;
        logic [31:0] ra, rb;
        logic [1:0]  ro;
        n_compared   = 0;
        n_mismatched = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        op       = '0;
        tick();
        tick();
        check("reset.running", {31'b0, is_running}, 32'd0);
        check("reset.done", {31'b0, done}, 32'd0);
        check("reset.quotient", quotient_out, 32'd0);
        check("reset.remainder", remainder_out, 32'd0);
        rst = 1'b0;
        tick();

        // Directed corners
        run_div("udiv_100_7", 32'd100, 32'd7, 2'b10);
        run_div("umod_100_7", 32'd100, 32'd7, 2'b11);
        run_div("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 2'b00);
        run_div("smod_7_m2", 32'd7, 32'hFFFF_FFFE, 2'b01);
        run_div("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
        run_div("udiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 2'b10);
        run_div("sdiv_zero", 32'h1234_5678, 32'd0, 2'b00);
        run_div("udiv_zero", 32'h1234_5678, 32'd0, 2'b10);
        run_div("sdiv_negzero", 32'hF000_0001, 32'd0, 2'b01);

        // Start while busy: second request at cycle 10 must be ignored
        dividend = 32'd100; divisor = 32'd7; op = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat, run_ok);
        lat += 10;
        $display("busy_start q=%h r=%h lat=%0d", quotient_out, remainder_out, lat);
        check("busy.latency", 32'(lat), 32'd32);
        check("busy.quotient", quotient_out, 32'd14);
        check("busy.remainder", remainder_out, 32'd2);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) extra++;
        end
        check("busy.no_second_done", 32'(extra), 32'd0);
        run_div("after_busy_9_3", 32'd9, 32'd3, 2'b10);

        // Start held high through FINISH is accepted only once IDLE is re-entered
        dividend = 32'd100; divisor = 32'd7; op = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 32; i++) tick();
        dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        tick();
        check("held.done", {31'b0, done}, 32'd1);
        check("held.quotient", quotient_out, 32'd14);
        tick();
        check("held.idle_gap", {31'b0, is_running}, 32'd0);
        tick();
        start = 1'b0;
        check("held.accepted", {31'b0, is_running}, 32'd1);
        wait_done(lat, run_ok);
        $display("held_start q=%h r=%h lat=%0d", quotient_out, remainder_out, lat);
        check("held.latency", 32'(lat), 32'd32);
        check("held.quotient2", quotient_out, 32'd3);
        check("held.remainder2", remainder_out, 32'd0);
        tick();

        // Reset mid-operation
        dividend = 32'd1000; divisor = 32'd9; op = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("midreset running=%0d done=%0d q=%h r=%h", is_running, done, quotient_out, remainder_out);
        check("midrst.running", {31'b0, is_running}, 32'd0);
        check("midrst.done", {31'b0, done}, 32'd0);
        check("midrst.quotient", quotient_out, 32'd0);
        check("midrst.remainder", remainder_out, 32'd0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) extra++;
        end
        check("midrst.no_done", 32'(extra), 32'd0);
        run_div("after_reset", 32'hDEAD_BEEF, 32'd12345, 2'b00);

        // Random operands
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'($urandom_range(1, 15));
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom >> $urandom_range(0, 31);
                3: rb = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                4: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 7));
                default: rb = $urandom;
            endcase
            ro = 2'($urandom_range(0, 3));
            run_div("rand", ra, rb, ro);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
